// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg
// Shared constants and types for the data-memory arbiter.
//   XLEN        : datapath width of the RV32 core
//   arb_state_e : response-tracking FSM states
//   REQ_CORE    : requester index of the core load/store path
//   REQ_DBG     : requester index of the debug/loader port
package dmem_arbiter_pkg;

   localparam int unsigned XLEN = 32;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      RSP_FRESH = 2'd1,
      RSP_HOLD  = 2'd2
   } arb_state_e;

   localparam int unsigned REQ_CORE = 0;
   localparam int unsigned REQ_DBG  = 1;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2
// Purely combinational two-way round-robin pick.
//   i_valid  : request valid per requester
//   i_last   : requester that won the most recent accepted transfer
//   i_enable : arbitration allowed this cycle; grant is 0 otherwise
//   o_grant  : one-hot grant (or 0)
module rr_arb2
   import dmem_arbiter_pkg::*;
(
   input  logic [1:0] i_valid,
   input  logic       i_last,
   input  logic       i_enable,
   output logic [1:0] o_grant
);

   always_comb begin
      o_grant = 2'b00;
      if (i_enable) begin
         if (i_valid == 2'b11) begin
            // Tie: the requester that did not win last time goes first.
            if (i_last) begin
               o_grant[REQ_CORE] = 1'b1;
            end else begin
               o_grant[REQ_DBG] = 1'b1;
            end
         end else begin
            o_grant = i_valid;
         end
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares the single-port data memory between the core (requester 0) and the
// debug/loader port (requester 1). One access granted per cycle, one response
// outstanding, response channel backpressured per requester.
//   clk_i, rstn_i            : clock, asynchronous active-low reset
//   req_valid_i/req_ready_o  : request handshake, one bit per requester
//   req_we_i/addr/wdata/be   : request fields per requester
//   rsp_valid_o/rsp_ready_i  : one-hot response handshake
//   rsp_rdata_o, rsp_err_o   : read data (0 for writes/errors), range error
//   mem_*                    : memory port; mem_rdata_i valid one cycle after
//                              a read strobe
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int unsigned     MEM_WORDS = 2048,
   parameter logic [XLEN-1:0] MEM_BASE  = 32'h0000_0000
) (
   input  logic                         clk_i,
   input  logic                         rstn_i,
   input  logic [1:0]                   req_valid_i,
   output logic [1:0]                   req_ready_o,
   input  logic [1:0]                   req_we_i,
   input  logic [1:0][XLEN-1:0]         req_addr_i,
   input  logic [1:0][XLEN-1:0]         req_wdata_i,
   input  logic [1:0][3:0]              req_be_i,
   output logic [1:0]                   rsp_valid_o,
   input  logic [1:0]                   rsp_ready_i,
   output logic [XLEN-1:0]              rsp_rdata_o,
   output logic                         rsp_err_o,
   output logic                         mem_req_o,
   output logic                         mem_we_o,
   output logic [$clog2(MEM_WORDS)-1:0] mem_addr_o,
   output logic [XLEN-1:0]              mem_wdata_o,
   output logic [3:0]                   mem_be_o,
   input  logic [XLEN-1:0]              mem_rdata_i
);

   localparam int unsigned     AW        = $clog2(MEM_WORDS);
   localparam logic [XLEN-1:0] MEM_BYTES = XLEN'(MEM_WORDS * 4);

   arb_state_e      r_state;
   arb_state_e      w_state_next;
   logic            r_last;
   logic            r_owner;
   logic            r_we;
   logic            r_err;
   logic [XLEN-1:0] r_hold;

   logic            w_busy;
   logic            w_rsp_fire;
   logic            w_enable;
   logic [1:0]      w_grant;
   logic            w_accept;
   logic            w_sel;
   logic [XLEN-1:0] w_off;
   logic            w_in_range;
   logic            w_mem_req;
   logic [XLEN-1:0] w_rd;

   assign w_busy     = (r_state != IDLE);
   assign w_rsp_fire = w_busy & rsp_ready_i[r_owner];
   // Gating with rstn_i keeps every strobe low while reset is held.
   assign w_enable   = rstn_i & (~w_busy | w_rsp_fire);

   rr_arb2 u_rr_arb2 (
      .i_valid  (req_valid_i),
      .i_last   (r_last),
      .i_enable (w_enable),
      .o_grant  (w_grant)
   );

   assign w_accept   = |w_grant;
   assign w_sel      = w_grant[REQ_DBG];
   // Unsigned wrap makes addresses below MEM_BASE land out of range too.
   assign w_off      = req_addr_i[w_sel] - MEM_BASE;
   assign w_in_range = (w_off < MEM_BYTES);
   assign w_mem_req  = w_accept & w_in_range;

   assign req_ready_o = w_grant;
   assign mem_req_o   = w_mem_req;
   assign mem_we_o    = w_mem_req & req_we_i[w_sel];
   assign mem_addr_o  = w_mem_req ? w_off[AW+1:2] : '0;
   assign mem_wdata_o = w_mem_req ? req_wdata_i[w_sel] : '0;
   assign mem_be_o    = w_mem_req ? req_be_i[w_sel] : 4'b0000;

   always_comb begin
      rsp_valid_o = 2'b00;
      if (w_busy) begin
         rsp_valid_o[r_owner] = 1'b1;
      end
   end

   // Fresh responses bypass straight from memory; stalled ones replay hold.
   assign w_rd        = (r_state == RSP_FRESH) ? mem_rdata_i : r_hold;
   assign rsp_rdata_o = (w_busy & ~r_we & ~r_err) ? w_rd : '0;
   assign rsp_err_o   = w_busy & r_err;

   always_comb begin
      w_state_next = r_state;
      if (w_accept) begin
         w_state_next = RSP_FRESH;
      end else if (w_rsp_fire) begin
         w_state_next = IDLE;
      end else if (r_state == RSP_FRESH) begin
         w_state_next = RSP_HOLD;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_state <= IDLE;
         r_last  <= 1'b1;
         r_owner <= 1'b0;
         r_we    <= 1'b0;
         r_err   <= 1'b0;
         r_hold  <= '0;
      end else begin
         r_state <= w_state_next;
         if (r_state == RSP_FRESH) begin
            r_hold <= mem_rdata_i;
         end
         if (w_accept) begin
            r_last  <= w_sel;
            r_owner <= w_sel;
            r_we    <= req_we_i[w_sel];
            r_err   <= ~w_in_range;
         end
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
   import dmem_arbiter_pkg::*;

   localparam int unsigned MEM_WORDS = 2048;
   localparam int unsigned AW        = 11;

   logic                 clk;
   logic                 rstn;
   logic [1:0]           req_valid;
   logic [1:0]           req_ready;
   logic [1:0]           req_we;
   logic [1:0][XLEN-1:0] req_addr;
   logic [1:0][XLEN-1:0] req_wdata;
   logic [1:0][3:0]      req_be;
   logic [1:0]           rsp_valid;
   logic [1:0]           rsp_ready;
   logic [XLEN-1:0]      rsp_rdata;
   logic                 rsp_err;
   logic                 mem_req;
   logic                 mem_we;
   logic [AW-1:0]        mem_addr;
   logic [XLEN-1:0]      mem_wdata;
   logic [3:0]           mem_be;
   logic [XLEN-1:0]      mem_rdata_q;

   int vectors;
   int miscompares;

   dmem_arbiter #(
      .MEM_WORDS (MEM_WORDS),
      .MEM_BASE  (32'h0000_0000)
   ) dut (
      .clk_i       (clk),
      .rstn_i      (rstn),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .req_we_i    (req_we),
      .req_addr_i  (req_addr),
      .req_wdata_i (req_wdata),
      .req_be_i    (req_be),
      .rsp_valid_o (rsp_valid),
      .rsp_ready_i (rsp_ready),
      .rsp_rdata_o (rsp_rdata),
      .rsp_err_o   (rsp_err),
      .mem_req_o   (mem_req),
      .mem_we_o    (mem_we),
      .mem_addr_o  (mem_addr),
      .mem_wdata_o (mem_wdata),
      .mem_be_o    (mem_be),
      .mem_rdata_i (mem_rdata_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: read data valid only the cycle after a read strobe.
   logic [XLEN-1:0] mem [MEM_WORDS];
   logic            pl_en;
   logic [AW-1:0]   pl_addr;
   logic [XLEN-1:0] pl_data;

   always @(posedge clk) begin
      if (pl_en) mem[pl_addr] <= pl_data;
      if (mem_req && mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
         end
      end
      mem_rdata_q <= (mem_req && !mem_we) ? mem[mem_addr] : 32'hBAD0_BAD0;
   end

   task automatic next_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
      pl_en   = 1'b1;
      pl_addr = a;
      pl_data = d;
      next_edge();
      pl_en   = 1'b0;
   endtask

   task automatic test_reset();
      rstn      = 1'b0;
      req_valid = 2'b11;
      req_addr  = {32'h0000_0008, 32'h0000_0004};
      rsp_ready = 2'b11;
      #3;
      vectors++;
      if (req_ready !== 2'b00) begin
         miscompares++; $display("FAIL reset_ready: got %b want 00", req_ready);
      end
      vectors++;
      if ({req_ready, rsp_valid, rsp_rdata, rsp_err, mem_req, mem_we, mem_addr, mem_wdata,
           mem_be} !== '0) begin
         miscompares++; $display("FAIL reset_outputs: some output nonzero, mem_req=%b rsp_valid=%b",
                                 mem_req, rsp_valid);
      end
      next_edge();
      req_valid = 2'b00;
      rstn      = 1'b1;
      next_edge();
   endtask

   task automatic test_contention();
      logic [1:0] exp_g;
      logic [1:0] prev_g;
      int         accepts;
      accepts   = 0;
      prev_g    = 2'b00;
      req_we    = 2'b00;
      req_addr  = {32'h0000_0200, 32'h0000_0100};
      rsp_ready = 2'b11;
      req_valid = 2'b11;
      for (int k = 0; k < 8; k++) begin
         exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
         @(negedge clk);
         vectors++;
         if (req_ready !== exp_g) begin
            miscompares++; $display("FAIL contention_grant[%0d]: got %b want %b", k, req_ready, exp_g);
         end
         if (k > 0) begin
            vectors++;
            if (rsp_valid !== prev_g) begin
               miscompares++; $display("FAIL contention_rsp[%0d]: got %b want %b", k, rsp_valid, prev_g);
            end
         end
         if (req_ready != 2'b00) accepts++;
         prev_g = exp_g;
         next_edge();
      end
      req_valid = 2'b00;
      @(negedge clk);
      vectors++;
      if (rsp_valid !== 2'b10) begin
         miscompares++; $display("FAIL contention_last_rsp: got %b want 10", rsp_valid);
      end
      vectors++;
      if (accepts !== 8) begin
         miscompares++; $display("FAIL contention_count: got %0d want 8", accepts);
      end
      next_edge();
   endtask

   task automatic test_single_read();
      preload(11'd5, 32'hDEAD_BEEF);
      req_we[0]   = 1'b0;
      req_addr[0] = 32'h0000_0014;
      req_valid   = 2'b01;
      @(negedge clk);
      vectors++;
      if ({req_ready, mem_req, mem_addr} !== {2'b01, 1'b1, 11'd5}) begin
         miscompares++; $display("FAIL read_accept: got ready=%b req=%b addr=%0d want 01/1/5",
                                 req_ready, mem_req, mem_addr);
      end
      next_edge();
      req_valid = 2'b00;
      @(negedge clk);
      vectors++;
      if ({rsp_valid, rsp_rdata, rsp_err} !== {2'b01, 32'hDEAD_BEEF, 1'b0}) begin
         miscompares++; $display("FAIL read_rsp: got valid=%b data=%h err=%b want 01/deadbeef/0",
                                 rsp_valid, rsp_rdata, rsp_err);
      end
      next_edge();
   endtask

   task automatic test_backpressure();
      preload(11'd3, 32'h1234_5678);
      preload(11'd4, 32'h0000_4444);
      rsp_ready   = 2'b01;
      req_we[1]   = 1'b0;
      req_addr[1] = 32'h0000_000C;
      req_valid   = 2'b10;
      @(negedge clk);
      vectors++;
      if ({req_ready, mem_req, mem_addr} !== {2'b10, 1'b1, 11'd3}) begin
         miscompares++; $display("FAIL bp_accept: got ready=%b req=%b addr=%0d want 10/1/3",
                                 req_ready, mem_req, mem_addr);
      end
      next_edge();
      req_addr[1] = 32'h0000_0010;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         vectors++;
         if ({rsp_valid, rsp_rdata, req_ready} !== {2'b10, 32'h1234_5678, 2'b00}) begin
            miscompares++; $display("FAIL bp_stall[%0d]: got valid=%b data=%h ready=%b want 10/12345678/00",
                                    k, rsp_valid, rsp_rdata, req_ready);
         end
         next_edge();
      end
      rsp_ready = 2'b11;
      @(negedge clk);
      vectors++;
      if ({rsp_valid, rsp_rdata, req_ready, mem_addr} !== {2'b10, 32'h1234_5678, 2'b10, 11'd4}) begin
         miscompares++; $display("FAIL bp_release: got valid=%b data=%h ready=%b addr=%0d",
                                 rsp_valid, rsp_rdata, req_ready, mem_addr);
      end
      next_edge();
      req_valid = 2'b00;
      @(negedge clk);
      vectors++;
      if ({rsp_valid, rsp_rdata} !== {2'b10, 32'h0000_4444}) begin
         miscompares++; $display("FAIL bp_second: got valid=%b data=%h want 10/00004444",
                                 rsp_valid, rsp_rdata);
      end
      next_edge();
   endtask

   task automatic test_write_read();
      preload(11'd16, 32'hFFFF_FFFF);
      req_we[0]    = 1'b1;
      req_addr[0]  = 32'h0000_0040;
      req_wdata[0] = 32'hA5A5_A5A5;
      req_be[0]    = 4'b0011;
      req_valid    = 2'b01;
      @(negedge clk);
      vectors++;
      if ({req_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_be} !==
          {2'b01, 1'b1, 1'b1, 11'd16, 32'hA5A5_A5A5, 4'b0011}) begin
         miscompares++; $display("FAIL wr_strobe: got we=%b addr=%0d wdata=%h be=%b",
                                 mem_we, mem_addr, mem_wdata, mem_be);
      end
      next_edge();
      req_we[0] = 1'b0;
      @(negedge clk);
      vectors++;
      if ({rsp_valid, rsp_rdata, req_ready, mem_we} !== {2'b01, 32'h0, 2'b01, 1'b0}) begin
         miscompares++; $display("FAIL wr_rsp: got valid=%b data=%h ready=%b we=%b",
                                 rsp_valid, rsp_rdata, req_ready, mem_we);
      end
      next_edge();
      req_valid = 2'b00;
      @(negedge clk);
      vectors++;
      if ({rsp_valid, rsp_rdata} !== {2'b01, 32'hFFFF_A5A5}) begin
         miscompares++; $display("FAIL rd_after_wr: got valid=%b data=%h want 01/ffffa5a5",
                                 rsp_valid, rsp_rdata);
      end
      next_edge();
   endtask

   task automatic test_out_of_range();
      req_we[0]   = 1'b0;
      req_addr[0] = 32'h0000_2000;
      req_valid   = 2'b01;
      @(negedge clk);
      vectors++;
      if ({req_ready, mem_req} !== {2'b01, 1'b0}) begin
         miscompares++; $display("FAIL oor_accept: got ready=%b mem_req=%b want 01/0", req_ready, mem_req);
      end
      next_edge();
      req_addr[0] = 32'h0000_1FFC;
      @(negedge clk);
      vectors++;
      if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b01, 1'b1, 32'h0}) begin
         miscompares++; $display("FAIL oor_rsp: got valid=%b err=%b data=%h want 01/1/0",
                                 rsp_valid, rsp_err, rsp_rdata);
      end
      vectors++;
      if ({req_ready, mem_req, mem_addr} !== {2'b01, 1'b1, 11'd2047}) begin
         miscompares++; $display("FAIL top_word: got ready=%b req=%b addr=%0d want 01/1/2047",
                                 req_ready, mem_req, mem_addr);
      end
      next_edge();
      req_valid = 2'b00;
      @(negedge clk);
      vectors++;
      if ({rsp_valid, rsp_err} !== {2'b01, 1'b0}) begin
         miscompares++; $display("FAIL top_word_rsp: got valid=%b err=%b want 01/0", rsp_valid, rsp_err);
      end
      next_edge();
   endtask

   task automatic test_reset_mid();
      rsp_ready   = 2'b00;
      req_we[1]   = 1'b0;
      req_addr[1] = 32'h0000_000C;
      req_valid   = 2'b10;
      next_edge();
      req_valid = 2'b00;
      next_edge();
      @(negedge clk);
      vectors++;
      if ({rsp_valid, rsp_rdata} !== {2'b10, 32'h1234_5678}) begin
         miscompares++; $display("FAIL mid_hold: got valid=%b data=%h want 10/12345678",
                                 rsp_valid, rsp_rdata);
      end
      #2;
      req_valid   = 2'b11;
      req_addr[0] = 32'h0000_0004;
      rstn        = 1'b0;
      #1;
      vectors++;
      if ({req_ready, rsp_valid, rsp_rdata, rsp_err, mem_req, mem_we, mem_addr, mem_wdata,
           mem_be} !== '0) begin
         miscompares++; $display("FAIL mid_reset: outputs nonzero, valid=%b ready=%b mem_req=%b",
                                 rsp_valid, req_ready, mem_req);
      end
      next_edge();
      vectors++;
      if (mem_req !== 1'b0) begin
         miscompares++; $display("FAIL mid_reset_strobe: got %b want 0", mem_req);
      end
      rstn      = 1'b1;
      rsp_ready = 2'b11;
      @(negedge clk);
      vectors++;
      if (req_ready !== 2'b01) begin
         miscompares++; $display("FAIL post_reset_tie: got %b want 01", req_ready);
      end
      next_edge();
      req_valid = 2'b00;
      @(negedge clk);
      vectors++;
      if (rsp_valid !== 2'b01) begin
         miscompares++; $display("FAIL post_reset_rsp: got %b want 01", rsp_valid);
      end
      next_edge();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      vectors     = 0;
      miscompares = 0;
      rstn        = 1'b0;
      req_valid   = 2'b00;
      req_we      = 2'b00;
      req_addr    = '0;
      req_wdata   = '0;
      req_be      = '0;
      rsp_ready   = 2'b11;
      pl_en       = 1'b0;
      pl_addr     = '0;
      pl_data     = '0;
      #12;
      test_reset();
      test_contention();
      test_single_read();
      test_backpressure();
      test_write_read();
      test_out_of_range();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter that shares the single-port data memory of the RV32 single-cycle core between the core load/store path (requester 0) and a debug/loader port (requester 1). It sits between the core's memory interface and the `dmem` array. It grants at most one access per cycle using round-robin, tracks one outstanding access, and returns read data on a backpressured response channel.

## Interface
Parameters:
- `MEM_WORDS`, 2048: data memory depth in 32-bit words; power of two.
- `MEM_BASE`, 32'h0000_0000: byte address mapped to word 0.

Ports:
- `clk_i`  in  1: clock; all state updates on the rising edge.
- `rstn_i`  in  1: reset, asynchronous, active-low.
- `req_valid_i`  in  [1:0]: request valid, one bit per requester.
- `req_ready_o`  out  [1:0]: request accepted this cycle.
- `req_we_i`  in  [1:0]: 1 = write, 0 = read.
- `req_addr_i`  in  [1:0][XLEN-1:0]: byte address; bits [1:0] are ignored.
- `req_wdata_i`  in  [1:0][XLEN-1:0]: write data.
- `req_be_i`  in  [1:0][3:0]: byte enables for writes.
- `rsp_valid_o`  out  [1:0]: response valid, one-hot.
- `rsp_ready_i`  in  [1:0]: response accepted.
- `rsp_rdata_o`  out  XLEN: read data; 0 for writes and errors.
- `rsp_err_o`  out  1: address was out of range.
- `mem_req_o`  out  1: memory access strobe.
- `mem_we_o`  out  1: memory write.
- `mem_addr_o`  out  $clog2(MEM_WORDS): word address.
- `mem_wdata_o`  out  XLEN: memory write data.
- `mem_be_o`  out  4: memory byte enables.
- `mem_rdata_i`  in  XLEN: read data, valid one cycle after a read strobe.

## Operation
- Handshake: a request transfers when `req_valid_i[i] & req_ready_o[i]`. Requesters hold all request fields stable until ready. At most one `req_ready_o` bit is high per cycle.
- Arbitration: if one requester is valid, it wins. If both are valid, the requester that is not `last_q` wins. `last_q` updates only on an accepted transfer.
- Eligibility: `req_ready_o` is high only when `state_q==IDLE`, or when the pending response is accepted in this same cycle (`rsp_valid_o[own] & rsp_ready_i[own]`).
- Range check: an access is in range if `addr - MEM_BASE < MEM_WORDS*4`, computed unsigned at XLEN width.
- In-range access: asserts `mem_req_o` in the accept cycle with `mem_addr_o = (addr-MEM_BASE)[..:2]`, and passes `we`, `wdata` and `be` through.
- Out-of-range access: `mem_req_o` stays 0, and the response carries `rsp_err_o=1` and `rsp_rdata_o=0`.
- FSM `state_q`:
  - IDLE: no response pending.
  - RSP_FRESH: the response is presented in the cycle after accept. Read data comes directly from `mem_rdata_i` and is captured into `hold_q` in the same cycle.
  - RSP_HOLD: the response is stalled; data comes from `hold_q`.
- Transitions:
  - IDLE→RSP_FRESH on accept.
  - RSP_FRESH→IDLE when the response is accepted and there is no new accept.
  - RSP_FRESH→RSP_FRESH when the response is accepted and a new accept occurs in the same cycle.
  - RSP_FRESH→RSP_HOLD when the response is not accepted.
  - RSP_HOLD→IDLE or RSP_FRESH on response accept, by the same rule as from RSP_FRESH.
- `owner_q`, `we_q` and `err_q` are captured on accept and select `rsp_valid_o`, data zeroing and `rsp_err_o`.

## Timing
- Reset values: `state_q`=IDLE, `last_q`=1 (so requester 0 wins the first tie), `hold_q`=0. All outputs are 0: `req_ready_o`, `rsp_valid_o`, `rsp_rdata_o`, `rsp_err_o`, `mem_req_o`, `mem_we_o`, `mem_addr_o`, `mem_wdata_o`, `mem_be_o`.
- Latency: the response appears 1 cycle after accept. With `rsp_ready_i` held high, throughput is 1 access/cycle.
- Request outputs are combinational from `req_*_i`, `state_q`, `last_q` and `rsp_ready_i`. There is no combinational path from `mem_rdata_i` to any `req_ready_o`.
- A memory write lands at the edge that ends the accept cycle. A read of the same word accepted in the next cycle returns the new data.
- Reset asserted mid-operation drops the pending response at once, asynchronously. No memory strobe is issued while `rstn_i`=0.

## Structure
- `riscv_pkg` additions: `XLEN` (existing), `arb_state_e {IDLE, RSP_FRESH, RSP_HOLD}`, `REQ_CORE=0`, `REQ_DBG=1`.
- Sub-module `rr_arb2`: a purely combinational 2-way round-robin pick taking `valid[1:0]`, `last` and `enable`, and producing one-hot `grant`. `dmem_arbiter` instantiates it once.

## Test plan
- Single read, core only: preload word 5 = 32'hDEAD_BEEF; core reads addr 32'h14 → `mem_req_o` in cycle 0; `rsp_valid_o`=2'b01 and `rsp_rdata_o`=32'hDEAD_BEEF in cycle 1.
- Contention: both requesters valid every cycle with `rsp_ready_i`=2'b11 → grants alternate 0,1,0,1 starting with 0; 8 accesses occur in 8 cycles.
- Backpressure: dbg reads word 3 = 32'h1234_5678 with `rsp_ready_i[1]`=0 for 3 cycles → `rsp_rdata_o` holds 32'h1234_5678 throughout; `req_ready_o`=0 while pending; a new accept occurs in the same cycle `rsp_ready_i[1]` rises.
- Write then read: core writes 32'hA5A5_A5A5 with `be`=4'b0011 to addr 32'h40 (old value 32'hFFFF_FFFF), then reads it next cycle → returns 32'hFFFF_A5A5.
- Out of range: read addr `MEM_BASE+MEM_WORDS*4` → `mem_req_o`=0, `rsp_err_o`=1, `rsp_rdata_o`=0.
- Reset mid-operation: deassert `rstn_i` while in RSP_HOLD → all outputs 0 immediately; after release, first tie goes to requester 0.
